// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the two-client memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE -> BUSY -> GAP -> IDLE)
//   client_t    : client identifier, CLI_I (instruction cache) / CLI_D (data cache)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    CLI_I = 1'b0,
    CLI_D = 1'b1
  } client_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner selection between the I-cache and D-cache clients.
// Purely combinational; only meaningful when at least one request is present.
//   Build option MEM_ARBITER_RR_EN:
//     undefined : fixed priority, D-cache wins simultaneous requests
//     defined   : round-robin, the client not granted last wins a tie
// Ports:
//   ic_req     in  I-cache is requesting
//   dc_req     in  D-cache is requesting (read or write)
//   last_grant in  client granted most recently (round-robin pointer)
//   winner     out selected client
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    ic_req,
  input  logic    dc_req,
  input  client_t last_grant,
  output client_t winner
);

  always_comb begin
    winner = CLI_D;
`ifdef MEM_ARBITER_RR_EN
    if (ic_req && dc_req) begin
      winner = (last_grant == CLI_D) ? CLI_I : CLI_D;
    end else if (ic_req) begin
      winner = CLI_I;
    end
`else
    if (ic_req && !dc_req) begin
      winner = CLI_I;
    end
`endif
  end

`ifndef MEM_ARBITER_RR_EN
  // The pointer is not consulted under fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a read-only I-cache client and
// a read/write D-cache client.
//   Build option MEM_ARBITER_RR_EN selects round-robin instead of fixed
//   D-cache priority (see mem_arb_pick).
// Handshake: a client holds *_mem_read / dc_mem_write (with address/data)
// until it sees its *_mem_ready pulse; it may withdraw, but a grant is never
// revoked. Toward memory, mem_read/mem_write/mem_addr/mem_wdata come straight
// from registers, stay constant for the whole grant, and the single-cycle
// mem_ready pulse completes the transfer. Memory read data is passed to both
// clients unconditionally; only the ready strobe is steered.
// Ports:
//   clk, proc_reset_n             clock (rising edge), async active-low reset
//   ic_mem_read/addr              I-cache refill request
//   ic_mem_rdata/ready            I-cache response
//   dc_mem_read/write/addr/wdata  D-cache refill / write-back request
//   dc_mem_rdata/ready            D-cache response
//   mem_read/write/addr/wdata     memory request (registered)
//   mem_rdata/ready               memory response
//   dbg_state                     current FSM state
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              ic_mem_read,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  output logic [LINE_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [LINE_W-1:0] dc_mem_wdata,
  output logic [LINE_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output arb_state_t        dbg_state
);

  arb_state_t        state_q, state_d;
  client_t           grant_q;
  client_t           rr_last_q;
  client_t           winner;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;

  logic dc_req, any_req, start, done;

  assign dc_req  = dc_mem_read | dc_mem_write;
  assign any_req = ic_mem_read | dc_req;
  assign start   = (state_q == ST_IDLE) && any_req;
  // mem_ready only counts while a grant is outstanding.
  assign done    = (state_q == ST_BUSY) && mem_ready;

  mem_arb_pick u_pick (
    .ic_req     (ic_mem_read),
    .dc_req     (dc_req),
    .last_grant (rr_last_q),
    .winner     (winner)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_BUSY;
      ST_BUSY: if (mem_ready) state_d = ST_BUSY == state_q ? ST_GAP : ST_BUSY;
      // One dead cycle so the finishing client's follow-up request is
      // sampled only after it has seen its ready.
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request registers: loaded on grant, cleared on completion.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      grant_q     <= CLI_D;
      rr_last_q   <= CLI_I;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (start) begin
      grant_q   <= winner;
      rr_last_q <= winner;
      if (winner == CLI_D) begin
        // read+write together is a write-back.
        mem_read_q  <= ~dc_mem_write;
        mem_write_q <= dc_mem_write;
        mem_addr_q  <= dc_mem_addr;
        mem_wdata_q <= dc_mem_write ? dc_mem_wdata : '0;
      end else begin
        mem_read_q  <= 1'b1;
        mem_write_q <= 1'b0;
        mem_addr_q  <= ic_mem_addr;
        mem_wdata_q <= '0;
      end
    end else if (done) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end
  end

  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

  assign ic_mem_ready = done && (grant_q == CLI_I);
  assign dc_mem_ready = done && (grant_q == CLI_D);
  assign ic_mem_rdata = mem_rdata;
  assign dc_mem_rdata = mem_rdata;

  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 28;
  localparam int LW = 128;
  localparam int EW = LW + 1;   // {client_is_d, line}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic proc_reset_n;

  // ---------------- DUT signals ----------------
  logic          ic_mem_read;
  logic [AW-1:0] ic_mem_addr;
  logic [LW-1:0] ic_mem_rdata;
  logic          ic_mem_ready;
  logic          dc_mem_read, dc_mem_write;
  logic [AW-1:0] dc_mem_addr;
  logic [LW-1:0] dc_mem_wdata;
  logic [LW-1:0] dc_mem_rdata;
  logic          dc_mem_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;
  arb_state_t    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .ic_mem_read  (ic_mem_read),
    .ic_mem_addr  (ic_mem_addr),
    .ic_mem_rdata (ic_mem_rdata),
    .ic_mem_ready (ic_mem_ready),
    .dc_mem_read  (dc_mem_read),
    .dc_mem_write (dc_mem_write),
    .dc_mem_addr  (dc_mem_addr),
    .dc_mem_wdata (dc_mem_wdata),
    .dc_mem_rdata (dc_mem_rdata),
    .dc_mem_ready (dc_mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;

  localparam logic [LW-1:0] WB_DATA = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model contents: each line repeats {A, addr} four times.
  function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
    return {4{4'hA, a}};
  endfunction

  // ---------------- memory responder ----------------
  bit            mem_auto = 1'b0;
  int            mem_lat  = 4;
  logic          auto_ready = 1'b0;
  logic [LW-1:0] auto_rdata = '0;
  logic          man_ready;
  logic [LW-1:0] man_rdata;

  assign mem_ready = mem_auto ? auto_ready : man_ready;
  assign mem_rdata = mem_auto ? auto_rdata : man_rdata;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (auto_ready) begin
        auto_ready = 1'b0;
        cnt = 0;
      end else if (mem_auto && (mem_read || mem_write)) begin
        cnt++;
        if (cnt >= mem_lat) begin
          auto_ready = 1'b1;
          auto_rdata = line_for(mem_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (ic_mem_ready || dc_mem_ready) begin
      if (ic_mem_ready && dc_mem_ready) begin
        check("ready_onehot", EW'({ic_mem_ready, dc_mem_ready}), EW'(2'b01));
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: ic=%0b dc=%0b with nothing outstanding", ic_mem_ready, dc_mem_ready);
      end else begin
        mon_exp = exp_q.pop_front();
        check("response", {dc_mem_ready, (dc_mem_ready ? dc_mem_rdata : ic_mem_rdata)}, mon_exp);
      end
    end
  end

  // ---------------- client drivers ----------------
  task automatic i_read(input logic [AW-1:0] a);
    bit got;
    got = 1'b0;
    ic_mem_read = 1'b1;
    ic_mem_addr = a;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = ic_mem_ready;
    end
    check("ic_handshake", EW'(got), EW'(1'b1));
    @(posedge clk); #1;
    ic_mem_read = 1'b0;
  endtask

  task automatic d_op(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    bit got;
    got = 1'b0;
    dc_mem_read  = rd;
    dc_mem_write = wr;
    dc_mem_addr  = a;
    dc_mem_wdata = wd;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = dc_mem_ready;
    end
    check("dc_handshake", EW'(got), EW'(1'b1));
    @(posedge clk); #1;
    dc_mem_read  = 1'b0;
    dc_mem_write = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    proc_reset_n = 1'b0;
    ic_mem_read  = 1'b0;
    ic_mem_addr  = '0;
    dc_mem_read  = 1'b0;
    dc_mem_write = 1'b0;
    dc_mem_addr  = '0;
    dc_mem_wdata = '0;
    man_ready    = 1'b0;
    man_rdata    = '0;

    // Reset state
    #2;
    check("rst_state", EW'(dbg_state), EW'(ST_IDLE));
    check("rst_mem_rw", EW'({mem_read, mem_write}), EW'(2'b00));
    check("rst_mem_addr", EW'(mem_addr), EW'(0));
    check("rst_mem_wdata", EW'(mem_wdata), EW'(0));
    check("rst_ready", EW'({ic_mem_ready, dc_mem_ready}), EW'(2'b00));
    repeat (3) @(negedge clk);
    proc_reset_n = 1'b1;
    mem_auto = 1'b1;
    mem_lat  = 4;

    // I-cache read alone, memory answers after 4 cycles
    @(posedge clk); #1;
    exp_q.push_back({1'b0, line_for(28'h0000010)});
    fork
      i_read(28'h0000010);
      begin
        @(negedge clk);
        check("t1_pre_grant", EW'(mem_read), EW'(1'b0));
        @(negedge clk);
        check("t1_mem_read", EW'({mem_read, mem_write}), EW'(2'b10));
        check("t1_mem_addr", EW'(mem_addr), EW'(28'h0000010));
        check("t1_mem_wdata", EW'(mem_wdata), EW'(0));
        check("t1_state", EW'(dbg_state), EW'(ST_BUSY));
      end
    join

    // Simultaneous I 0x20 / D 0x30, two rounds (D wins under both builds)
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      exp_q.push_back({1'b1, line_for(28'h0000030)});
      exp_q.push_back({1'b0, line_for(28'h0000020)});
      fork
        i_read(28'h0000020);
        d_op(1'b1, 1'b0, 28'h0000030, '0);
      join
    end

    // D alone with read+write both high behaves as a write
    @(posedge clk); #1;
    exp_q.push_back({1'b1, line_for(28'h0000090)});
    fork
      d_op(1'b1, 1'b1, 28'h0000090, WB_DATA);
      begin
        repeat (2) @(negedge clk);
        check("t2b_rw_is_write", EW'({mem_read, mem_write}), EW'(2'b01));
        check("t2b_wdata", EW'(mem_wdata), EW'(WB_DATA));
      end
    join

    // Tie right after a D grant: fixed -> D, round-robin -> I
    @(posedge clk); #1;
`ifdef MEM_ARBITER_RR_EN
    exp_q.push_back({1'b0, line_for(28'h00000A0)});
    exp_q.push_back({1'b1, line_for(28'h00000B0)});
`else
    exp_q.push_back({1'b1, line_for(28'h00000B0)});
    exp_q.push_back({1'b0, line_for(28'h00000A0)});
`endif
    fork
      i_read(28'h00000A0);
      d_op(1'b1, 1'b0, 28'h00000B0, '0);
    join

    // Write-back 0x40, immediate D refill 0x50, I 0x60 pending
    mem_lat = 3;
    @(posedge clk); #1;
    exp_q.push_back({1'b1, line_for(28'h0000040)});
`ifdef MEM_ARBITER_RR_EN
    exp_q.push_back({1'b0, line_for(28'h0000060)});
    exp_q.push_back({1'b1, line_for(28'h0000050)});
`else
    exp_q.push_back({1'b1, line_for(28'h0000050)});
    exp_q.push_back({1'b0, line_for(28'h0000060)});
`endif
    fork
      begin
        d_op(1'b0, 1'b1, 28'h0000040, WB_DATA);
        d_op(1'b1, 1'b0, 28'h0000050, '0);
      end
      begin
        @(posedge clk); #1;
        i_read(28'h0000060);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          seen = mem_write;
        end
        check("t3_write_granted", EW'(seen), EW'(1'b1));
        for (int c = 0; c < 20; c++) begin
          check("t3_wdata_hold", EW'(mem_wdata), EW'(WB_DATA));
          check("t3_addr_hold", EW'(mem_addr), EW'(28'h0000040));
          if (dc_mem_ready) break;
          @(negedge clk);
        end
        @(negedge clk);
        check("t3_gap_state", EW'(dbg_state), EW'(ST_GAP));
        check("t3_gap_idle_bus", EW'({mem_read, mem_write}), EW'(2'b00));
        @(negedge clk);
        check("t3_back_idle", EW'(dbg_state), EW'(ST_IDLE));
        @(negedge clk);
        check("t3_next_grant", EW'({mem_read, mem_write}), EW'(2'b10));
`ifdef MEM_ARBITER_RR_EN
        check("t3_next_addr", EW'(mem_addr), EW'(28'h0000060));
`else
        check("t3_next_addr", EW'(mem_addr), EW'(28'h0000050));
`endif
      end
    join

    // Stray mem_ready while IDLE
    mem_auto = 1'b0;
    @(posedge clk); #1;
    man_ready = 1'b1;
    man_rdata = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    @(negedge clk);
    check("t4_no_ready", EW'({ic_mem_ready, dc_mem_ready}), EW'(2'b00));
    check("t4_rdata_passthru", EW'(dc_mem_rdata), EW'(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321));
    @(posedge clk); #1;
    man_ready = 1'b0;
    @(negedge clk);
    check("t4_still_idle", EW'(dbg_state), EW'(ST_IDLE));
    check("t4_bus_quiet", EW'({mem_read, mem_write, mem_addr}), EW'(0));

    // Reset in the middle of a grant
    @(posedge clk); #1;
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h0000070;
    repeat (2) @(negedge clk);
    check("t5_busy", EW'(dbg_state), EW'(ST_BUSY));
    #1 man_ready = 1'b1;
    #1 proc_reset_n = 1'b0;
    #1;
    check("t5_async_bus", EW'({mem_read, mem_write, mem_addr}), EW'(0));
    check("t5_async_ready", EW'({ic_mem_ready, dc_mem_ready}), EW'(2'b00));
    check("t5_async_state", EW'(dbg_state), EW'(ST_IDLE));
    ic_mem_read = 1'b0;
    man_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 man_ready = 1'b1;
    @(negedge clk);
    check("t5_ready_ignored", EW'({ic_mem_ready, dc_mem_ready}), EW'(2'b00));
    man_ready = 1'b0;
    @(negedge clk);
    proc_reset_n = 1'b1;
    mem_auto = 1'b1;
    mem_lat  = 2;
    exp_q.push_back({1'b1, line_for(28'h0000080)});
    fork
      d_op(1'b1, 1'b0, 28'h0000080, '0);
      begin
        @(negedge clk);
        check("t5_first_grant", EW'({mem_read, mem_write}), EW'(2'b10));
        check("t5_first_addr", EW'(mem_addr), EW'(28'h0000080));
      end
    join

    repeat (3) @(negedge clk);
    check("queue_drained", EW'(exp_q.size()), EW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, block (128-bit line) address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache line width in bits.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port proc_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ic_mem_read  input  1, ic_mem_addr  input  ADDR_W  for I-cache refill requests (read-only client).
REQ-006 SHALL have ports ic_mem_rdata  output  LINE_W, ic_mem_ready  output  1  as I-cache response.
REQ-007 SHALL have ports dc_mem_read, dc_mem_write  input  1, dc_mem_addr  input  ADDR_W, dc_mem_wdata  input  LINE_W  for D-cache refill/write-back.
REQ-008 SHALL have ports dc_mem_rdata  output  LINE_W, dc_mem_ready  output  1  as D-cache response.
REQ-009 SHALL have ports mem_read, mem_write  output  1, mem_addr  output  ADDR_W, mem_wdata  output  LINE_W  toward the single memory port.
REQ-010 SHALL have ports mem_rdata  input  LINE_W, mem_ready  input  1  from memory; mem_ready is a one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, GAP.
REQ-012 SHALL, in IDLE with any client request, pick a winner, latch its op/addr/wdata and go to BUSY next edge.
REQ-013 SHALL drive mem_read/mem_write/mem_addr/mem_wdata from registers only, asserted from the first BUSY cycle (one-cycle grant latency) and held constant throughout BUSY.
REQ-014 SHALL, in BUSY, forward mem_ready combinationally to the granted client's *_mem_ready only; the other client's ready stays 0.
REQ-015 SHALL drive ic_mem_rdata and dc_mem_rdata combinationally from mem_rdata at all times.
REQ-016 SHALL, on mem_ready in BUSY, clear mem_read/mem_write at that edge and go to GAP.
REQ-017 SHALL spend exactly one cycle in GAP with no grant, then return to IDLE, so the completed client's next request (e.g. refill after write-back) is seen fresh.
REQ-018 SHALL ignore mem_ready in IDLE and GAP.
REQ-019 SHALL treat dc_mem_read and dc_mem_write both high as a write.
REQ-020 SHALL not preempt: a grant lasts until mem_ready regardless of other requests or requester withdrawal.
REQ-021 SHALL, with no requests in IDLE, keep all memory-side outputs 0.

Reset
REQ-022 SHALL, while proc_reset_n is low, force state IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, ic_mem_ready=0, dc_mem_ready=0, latched grant=D, round-robin pointer=I.
REQ-023 SHALL abandon any in-flight transaction on reset mid-BUSY; no ready is forwarded afterward.
REQ-024 SHALL accept the first request in the first IDLE cycle after proc_reset_n rises.

Configuration
REQ-025 SHALL, without MEM_ARBITER_RR_EN, use fixed priority: D-cache wins simultaneous requests.
REQ-026 SHALL, with MEM_ARBITER_RR_EN defined, use round-robin: on simultaneous requests the client not granted last wins; pointer updates on each grant.

Structure
REQ-027 SHALL take FSM state encoding and client-id encoding (CLI_I, CLI_D) from shared package mem_arb_pkg.
REQ-028 SHALL place the priority/round-robin decision in sub-module mem_arb_pick; FSM and datapath registers stay in mem_arbiter.

Verification
REQ-029 SHALL cover: I read only, addr 0x000_0010, memory ready after 4 cycles -> mem_read=1 one cycle after request, ic_mem_ready pulses once with data, dc_mem_ready stays 0.
REQ-030 SHALL cover: simultaneous I read 0x0000020 and D read 0x0000030, fixed priority -> D served first, I served after GAP; RR build -> two rounds alternate D then I then D.
REQ-031 SHALL cover: D write-back 0x0000040 wdata 0xDEAD...BEEF then immediate D refill 0x0000050 with I pending -> write completes, one GAP cycle, next grant per priority, mem_wdata held stable throughout write.
REQ-032 SHALL cover: mem_ready pulse while IDLE -> no ready forwarded, outputs unchanged.
REQ-033 SHALL cover: proc_reset_n low mid-BUSY -> all outputs 0 asynchronously, later mem_ready ignored, new request granted after release.
